// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light display driver.
//   Lamp codes       : one-hot 3-bit green/yellow/red encodings.
//   Fault codes      : cause recorded on the first illegal input.
//   Digit slots      : the four scan positions of the display.
//   Segment patterns : active-low 7-seg constants (bit order g,f,e,d,c,b,a)
//                      plus the full 8-bit blank and fault patterns.
package traffic_pkg;

    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_RED    = 3'b100;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_ILLEGAL  = 2'b01,
        FAULT_CONFLICT = 2'b10,
        FAULT_RANGE    = 2'b11
    } fault_code_t;

    // Scan slot order: SN count, SN letter, EW count, EW letter.
    typedef enum logic [1:0] {
        DIG_SN_COUNT = 2'd0,
        DIG_SN_LAMP  = 2'd1,
        DIG_EW_COUNT = 2'd2,
        DIG_EW_LAMP  = 2'd3
    } digit_t;

    localparam logic [6:0] SEG_G    = 7'h42;
    localparam logic [6:0] SEG_Y    = 7'h11;
    localparam logic [6:0] SEG_R    = 7'h2F;
    localparam logic [6:0] SEG_DASH = 7'h3F;

    localparam logic [7:0] SEG_BLANK = 8'hFF;  // all segments and dp off
    localparam logic [7:0] SEG_FAULT = 8'h3F;  // dash with dp lit

    function automatic logic [6:0] digit_pattern(input logic [3:0] value);
        case (value)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return SEG_DASH;
        endcase
    endfunction

    function automatic logic [6:0] lamp_letter(input logic [2:0] code);
        case (code)
            LAMP_GREEN:  return SEG_G;
            LAMP_YELLOW: return SEG_Y;
            LAMP_RED:    return SEG_R;
            default:     return SEG_DASH;
        endcase
    endfunction

    function automatic logic lamp_legal(input logic [2:0] code);
        return (code == LAMP_GREEN) || (code == LAMP_YELLOW) || (code == LAMP_RED);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit value to active-low 7-segment pattern.
//   value   : input  [3:0] digit value; 10..15 render as a dash
//   pattern : output [6:0] segments g,f,e,d,c,b,a (low = lit)
module seg7_decode
    import traffic_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = digit_pattern(value);
    end

endmodule

// File: rtl/traffic_display.sv
// Four-digit multiplexed display for a two-way traffic light controller.
// Shows SN count, SN lamp letter, EW count, EW lamp letter in turn; count
// digits blink while both directions are red; any illegal input latches a
// sticky fault that turns every digit into a dash with dp lit.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sn_light    : input  [2:0] SN lamp code (001 G, 010 Y, 100 R)
//   ew_light    : input  [2:0] EW lamp code
//   sn_count    : input  [3:0] SN remaining seconds (0..9 legal)
//   ew_count    : input  [3:0] EW remaining seconds (0..9 legal)
//   seg         : output [7:0] active-low segments, bit7 = dp
//   dig_sel     : output [3:0] active-low digit enables
//   fault       : output       sticky fault flag
//   fault_code  : output [1:0] cause of the first fault
module traffic_display
    import traffic_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 50000,
    parameter int unsigned BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sn_light,
    input  logic [2:0] ew_light,
    input  logic [3:0] sn_count,
    input  logic [3:0] ew_count,
    output logic [7:0] seg,
    output logic [3:0] dig_sel,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [9:0]  BLINK_LAST = 10'(BLINK_DIV - 1);

    logic [15:0] scan_cnt;
    logic [9:0]  blink_cnt;
    logic        blink_phase;
    digit_t      idx_q, idx_d;
    logic [7:0]  seg_q, seg_d;
    logic [3:0]  dig_sel_q, dig_sel_d;
    logic        fault_q;
    fault_code_t fault_code_q, cause;
    logic        scan_tick;
    logic        all_red;
    logic [6:0]  sn_dec, ew_dec;

    seg7_decode u_sn_dec (.value(sn_count), .pattern(sn_dec));
    seg7_decode u_ew_dec (.value(ew_count), .pattern(ew_dec));

    assign scan_tick = (scan_cnt == SCAN_LAST);
    assign all_red   = (sn_light == LAMP_RED) && (ew_light == LAMP_RED);

    // Digit-slot sequencer: next state and display content.
    always_comb begin
        idx_d     = idx_q;
        seg_d     = SEG_BLANK;
        dig_sel_d = ~(4'b0001 << idx_q);

        if (scan_tick) begin
            unique case (idx_q)
                DIG_SN_COUNT: idx_d = DIG_SN_LAMP;
                DIG_SN_LAMP:  idx_d = DIG_EW_COUNT;
                DIG_EW_COUNT: idx_d = DIG_EW_LAMP;
                DIG_EW_LAMP:  idx_d = DIG_SN_COUNT;
            endcase
        end

        unique case (idx_q)
            DIG_SN_COUNT: seg_d = {1'b1, sn_dec};
            DIG_SN_LAMP:  seg_d = {1'b1, lamp_letter(sn_light)};
            DIG_EW_COUNT: seg_d = {1'b1, ew_dec};
            DIG_EW_LAMP:  seg_d = {1'b1, lamp_letter(ew_light)};
        endcase

        // All-red blinks only the numeric digits; letters stay steady.
        if (all_red && blink_phase &&
            ((idx_q == DIG_SN_COUNT) || (idx_q == DIG_EW_COUNT))) begin
            seg_d = SEG_BLANK;
        end

        if (fault_q) begin
            seg_d = SEG_FAULT;
        end
    end

    // Fault classification, highest priority first.
    always_comb begin
        cause = FAULT_NONE;
        if ((sn_light != LAMP_RED) && (ew_light != LAMP_RED)) begin
            cause = FAULT_CONFLICT;
        end else if (!lamp_legal(sn_light) || !lamp_legal(ew_light)) begin
            cause = FAULT_ILLEGAL;
        end else if ((sn_count > 4'd9) || (ew_count > 4'd9)) begin
            cause = FAULT_RANGE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt     <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            idx_q        <= DIG_SN_COUNT;
            seg_q        <= SEG_BLANK;
            dig_sel_q    <= 4'hF;
            fault_q      <= 1'b0;
            fault_code_q <= FAULT_NONE;
        end else begin
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            dig_sel_q <= dig_sel_d;

            if (scan_tick) begin
                scan_cnt <= '0;
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 10'd1;
                end
            end else begin
                scan_cnt <= scan_cnt + 16'd1;
            end

            // Only the first cause is kept; later faults and recovery are ignored.
            if (!fault_q && (cause != FAULT_NONE)) begin
                fault_q      <= 1'b1;
                fault_code_q <= cause;
            end
        end
    end

    assign seg        = seg_q;
    assign dig_sel    = dig_sel_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule
